// File: rtl/pll_dyn_pkg.sv
// Shared types for the runtime PLL profile controller: FSM states and 18-bit profile layout.
// Profile word = {idsel, fbdsel, odsel}, each a device-ready 6-bit code.
package pll_dyn_pkg;
    localparam int SEL_W  = 6;
    localparam int PROF_W = 3 * SEL_W;
    localparam int ID_LSB = 2 * SEL_W;
    localparam int FB_LSB = SEL_W;
    localparam int OD_LSB = 0;

    typedef logic [PROF_W-1:0] prof_t;

    typedef enum logic [2:0] {
        S_APPLY,
        S_HOLD,
        S_WAIT_LOCK,
        S_SETTLE,
        S_RUN,
        S_ERR
    } state_t;

    function automatic logic [SEL_W-1:0] prof_field(input prof_t p, input int lsb);
        return p[lsb +: SEL_W];
    endfunction
endpackage

// File: rtl/pll_dyn_ctrl_if.sv
// Profile request handshake and lock status between a host and pll_dyn_ctrl.
// master = host side, slave = controller side.
interface pll_dyn_ctrl_if #(parameter int PW = 2);
    logic          req_valid;
    logic [PW-1:0] req_prof;
    logic          req_ready;
    logic          done;
    logic          err;
    logic          locked;
    logic [PW-1:0] cur_prof;

    modport master (output req_valid, req_prof,
                    input  req_ready, done, err, locked, cur_prof);
    modport slave  (input  req_valid, req_prof,
                    output req_ready, done, err, locked, cur_prof);
endinterface

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for the asynchronous rPLL LOCK output.
// Latency 2 cycles; no backpressure.
module pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);
    logic meta_q, sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;
endmodule

// File: rtl/pll_dyn_ctrl.sv
// Runtime rPLL profile controller: reset hold, lock wait with retry, lock qualification.
// Request->done latency >= 1 + RST_CYCLES + 2 + LOCK_STABLE; requests accepted only in RUN/ERR.
// Optional PLL_LOCK_MON_EN: RUN lock loss triggers a relock through WAIT_LOCK without PLL reset.
module pll_dyn_ctrl
    import pll_dyn_pkg::*;
#(
    parameter int                    NPROF        = 4,
    parameter logic [NPROF*18-1:0]   PROF_TABLE   = '0,
    parameter int                    BOOT_PROF    = 0,
    parameter int                    RST_CYCLES   = 16,
    parameter int                    LOCK_TIMEOUT = 27000,
    parameter int                    LOCK_STABLE  = 256,
    parameter int                    MAX_RETRY    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pll_dyn_ctrl_if.slave        ctl,
    output logic                 pll_reset,
    output logic [SEL_W-1:0]     pll_idsel,
    output logic [SEL_W-1:0]     pll_fbdsel,
    output logic [SEL_W-1:0]     pll_odsel,
    input  logic                 pll_lock,
    output logic [7:0]           relock_cnt
);
    localparam int    PW    = (NPROF > 1) ? $clog2(NPROF) : 1;
    localparam int    CMAX0 = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
    localparam int    CMAX  = (CMAX0 > LOCK_TIMEOUT) ? CMAX0 : LOCK_TIMEOUT;
    localparam int    CW    = $clog2(CMAX + 1);
    localparam int    RW    = $clog2(MAX_RETRY + 1);
    localparam prof_t BOOT_CODE = PROF_TABLE[BOOT_PROF*PROF_W +: PROF_W];

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [RW-1:0]    retry_q;
    logic [PW-1:0]    cur_prof_q;
    logic             pll_reset_q, done_q, err_q, locked_q;
    logic [SEL_W-1:0] idsel_q, fbdsel_q, odsel_q;
    logic [7:0]       relock_q;

    logic             lock_s;
    logic             accept, req_ok;
    logic [RW-1:0]    retry_inc;
    prof_t            tgt;

    pll_lock_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (pll_lock),
        .sync_o  (lock_s)
    );

    assign ctl.req_ready = (state_q == S_RUN) || (state_q == S_ERR);
    assign accept        = ctl.req_valid && ctl.req_ready;
    assign req_ok        = 32'(ctl.req_prof) < NPROF;
    assign retry_inc     = retry_q + RW'(1);
    assign tgt           = PROF_TABLE[32'(cur_prof_q)*PROF_W +: PROF_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_APPLY;
            cnt_q       <= '0;
            retry_q     <= '0;
            cur_prof_q  <= PW'(BOOT_PROF);
            pll_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
            idsel_q     <= prof_field(BOOT_CODE, ID_LSB);
            fbdsel_q    <= prof_field(BOOT_CODE, FB_LSB);
            odsel_q     <= prof_field(BOOT_CODE, OD_LSB);
            relock_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_APPLY: begin
                    idsel_q     <= prof_field(tgt, ID_LSB);
                    fbdsel_q    <= prof_field(tgt, FB_LSB);
                    odsel_q     <= prof_field(tgt, OD_LSB);
                    pll_reset_q <= 1'b1;
                    locked_q    <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= S_HOLD;
                end
                S_HOLD: begin
                    if (cnt_q == CW'(RST_CYCLES - 1)) begin
                        pll_reset_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= S_WAIT_LOCK;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        cnt_q   <= '0;
                        state_q <= S_SETTLE;
                    end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                        retry_q <= retry_inc;
                        cnt_q   <= '0;
                        if (retry_inc < RW'(MAX_RETRY)) begin
                            state_q <= S_APPLY;
                        end else begin
                            state_q     <= S_ERR;
                            pll_reset_q <= 1'b1;
                            err_q       <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_SETTLE: begin
                    // A single low sample restarts qualification but is not a failed attempt.
                    if (!lock_s) begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT_LOCK;
                    end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
                        state_q  <= S_RUN;
                        locked_q <= 1'b1;
                        done_q   <= 1'b1;
                        retry_q  <= '0;
                        err_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RUN, S_ERR: begin
                    if (accept) begin
                        if (req_ok) begin
                            cur_prof_q <= ctl.req_prof;
                            retry_q    <= '0;
                            locked_q   <= 1'b0;
                            state_q    <= S_APPLY;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (state_q == S_RUN) begin
`ifdef PLL_LOCK_MON_EN
                        if (!lock_s) begin
                            locked_q <= 1'b0;
                            relock_q <= (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
                            retry_q  <= '0;
                            cnt_q    <= '0;
                            state_q  <= S_WAIT_LOCK;
                        end
`else
                        locked_q <= lock_s;
`endif
                    end
                end
                default: state_q <= S_APPLY;
            endcase
        end
    end

    assign ctl.done     = done_q;
    assign ctl.err      = err_q;
    assign ctl.locked   = locked_q;
    assign ctl.cur_prof = cur_prof_q;
    assign pll_reset    = pll_reset_q;
    assign pll_idsel    = idsel_q;
    assign pll_fbdsel   = fbdsel_q;
    assign pll_odsel    = odsel_q;
    assign relock_cnt   = relock_q;
endmodule

// File: doc/pll_dyn_ctrl.md
# pll_dyn_ctrl

Runtime PLL profile controller. It drives the dynamic IDSEL/FBDSEL/ODSEL and RESET inputs of an rPLL instance configured with `DYN_IDIV_SEL`/`DYN_FBDIV_SEL`/`DYN_ODIV_SEL` = "true". It sequences PLL reset, lock acquisition, lock qualification and retry, so the DDR test clock can switch between frequency profiles without reconfiguring the bitstream. It runs on the 27 MHz board oscillator, never on a PLL output.

## Interface
- `NPROF`, 4: number of profiles, ≥1.
- `PROF_TABLE`, all-zero: `NPROF*18` bits; profile k at bits `[18k+17:18k]` = {idsel, fbdsel, odsel}, device-ready 6-bit codes.
- `BOOT_PROF`, 0: profile applied after reset.
- `RST_CYCLES`, 16: PLL reset hold length, ≥2.
- `LOCK_TIMEOUT`, 27000: cycles allowed from reset release to first lock (1 ms).
- `LOCK_STABLE`, 256: consecutive locked cycles needed before the lock is qualified.
- `MAX_RETRY`, 3: attempts per request before error, ≥1.
- `clk` in 1: 27 MHz reference clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: profile change request.
- `req_prof` in `$clog2(NPROF)` (min 1): requested profile index.
- `req_ready` out 1: request can be accepted.
- `done` out 1: one-cycle pulse when a profile is qualified-locked.
- `err` out 1: last request failed (timeout or bad index).
- `locked` out 1: PLL qualified-locked with `cur_prof`.
- `cur_prof` out `$clog2(NPROF)`: profile currently applied.
- `pll_reset` out 1: to rPLL RESET.
- `pll_idsel`, `pll_fbdsel`, `pll_odsel` out 6 each: to rPLL dynamic selects.
- `pll_lock` in 1: rPLL LOCK, asynchronous to `clk`.
- `relock_cnt` out 8: saturating count of lock-loss recoveries.

## Operation
- States: APPLY, HOLD, WAIT_LOCK, SETTLE, RUN, ERR.
- Reset values:
  - state APPLY
  - `pll_reset`=1
  - selects = `BOOT_PROF` codes
  - `cur_prof`=`BOOT_PROF`
  - `req_ready`, `done`, `err`, `locked` = 0
  - `relock_cnt`=0
  - retry count 0
- APPLY, 1 cycle: load selects from the target profile, `pll_reset`=1, `locked`=0 → HOLD.
- HOLD: `pll_reset`=1 for `RST_CYCLES` cycles, then deassert → WAIT_LOCK with the timeout counter cleared.
- WAIT_LOCK:
  - synced lock high → SETTLE.
  - Timeout counter reaches `LOCK_TIMEOUT`-1: retry+1. If retry < `MAX_RETRY` → APPLY with the same profile; else → ERR.
- SETTLE:
  - Synced lock must stay high `LOCK_STABLE` consecutive cycles.
  - Any drop → WAIT_LOCK; the timeout counter restarts and retry is not incremented.
  - Success → RUN; `locked`=1, `done` pulses, retry cleared, `err` cleared.
- ERR: `pll_reset`=1 held, `locked`=0, `err`=1.
- `req_ready`=1 only in RUN and ERR. Accept on `req_valid`&&`req_ready`:
  - Valid index: `cur_prof`←`req_prof`, retry←0 → APPLY. Requesting the current profile still re-runs the sequence.
  - `req_prof` ≥ `NPROF`: accepted; `err`=1; state, selects and `locked` unchanged.
- RUN, lock loss: behaviour depends on `PLL_LOCK_MON_EN` (see Configuration). A simultaneous accepted request takes priority over lock loss.
- `rst_n` asserted in any state: immediate return to reset values; the boot sequence restarts after release.

## Timing
- `pll_lock` passes through a 2-flop synchroniser, so all lock decisions see it 2 cycles late.
- Minimum request-accept → `done` latency: 1 (APPLY) + `RST_CYCLES` + 2 (sync) + `LOCK_STABLE` cycles.
- `done` is high exactly one cycle: the first cycle in RUN. `locked` rises in the same cycle.
- Outputs are registered except `req_ready`, which decodes the state register.

## Configuration
- `PLL_LOCK_MON_EN` defined:
  - Synced lock low in RUN → `locked`=0, `relock_cnt`+1 (saturates at 255), retry←0 → WAIT_LOCK without PLL reset.
  - A WAIT_LOCK timeout then follows the normal retry path.
- Undefined:
  - RUN ignores lock loss except to drive `locked` = synced lock.
  - `relock_cnt` is tied to 0.

## Structure
- Package `pll_dyn_pkg`: state enum, 18-bit profile typedef and field-slice constants, select width constant (6).
- Sub-module `pll_lock_sync`: 2-flop synchroniser, async active-low reset to 0.

## Test plan
- Reset release, PLL model locks 10 cycles after `pll_reset` falls → `pll_reset` high for 17 cycles, `done` at cycle 17+10+2+256 (±1), `cur_prof`=0, selects = profile 0 codes.
- In RUN, request profile 2 → `req_ready` falls next cycle, selects = profile 2 codes, `done` again, `locked`=1, `cur_prof`=2.
- Model never locks → 3 HOLD pulses on `pll_reset`, then ERR with `err`=1 and `req_ready`=1; request profile 1 with a good model → `done`, `err`=0.
- Lock glitches low for 1 cycle at SETTLE cycle 100 → back to WAIT_LOCK; `done` is delayed by ≥256 cycles after the lock returns; retry count unchanged.
- `req_prof`=5 with `NPROF`=4 → `err`=1; `locked`, `cur_prof` and selects unchanged.
- With `PLL_LOCK_MON_EN`: drop lock in RUN for 50 cycles → `locked`=0, `relock_cnt`=1, no `pll_reset` pulse, `done` on requalification. Without the macro → `relock_cnt` stays 0.
